round_sequencer: RTL and testbench
==================================

ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: port clk (all state updates on posedge clk) and port reset (active-high, sampled on posedge clk).
REQ-002 SHALL have parameter SHOW_CYCLES, default 50_000_000, giving the number of cycles the pattern is displayed; legal range is 1 to 2^32-1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000, giving the answer window in cycles; legal range is 1 to 2^32-1.
REQ-004 SHALL have these ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- seq_ld  in  1  new-round request from the game controller.
- enter  in  1  raw player button level.
- sw  in  8  player answer switches.
- led  out  8  pattern display.
- seq_check  out  1  result of the last round; 1 = match.
- result_valid  out  1  one-cycle pulse when the round result is ready.
- timeout  out  1  one-cycle pulse when the round ended by timer expiry.
- busy  out  1  round in progress.
- state_out  out  3  current state encoding.

Function
REQ-005 SHALL implement states IDLE=0, LOAD=1, SHOW=2, ANSWER=3, RESULT=4; codes 5-7 SHALL go to IDLE on the next cycle.
REQ-006 SHALL generate enter_edge = enter & ~enter_prev, where enter_prev is a registered copy of enter.
REQ-007 In IDLE: led=0 and busy=0; seq_ld=1 SHALL move to LOAD on the next cycle.
REQ-008 SHALL ignore seq_ld in every state except IDLE.
REQ-009 In LOAD (exactly 1 cycle): the LFSR SHALL step once, seq_reg SHALL take the stepped value, the counter SHALL be set to SHOW_CYCLES-1, and the next state SHALL be SHOW.
REQ-010 LFSR: 8-bit Fibonacci form, next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, seed 8'hA5; SHALL never hold 0; SHALL step only in LOAD.
REQ-011 In SHOW: led=seq_reg and the counter SHALL decrement each cycle; in the cycle the counter is 0 the block SHALL load TIMEOUT_CYCLES-1 and move to ANSWER; led SHALL therefore be nonzero for exactly SHOW_CYCLES cycles.
REQ-012 SHALL ignore enter_edge in SHOW.
REQ-013 In ANSWER: led=0 and the counter SHALL decrement each cycle.
REQ-014 In ANSWER, enter_edge=1 SHALL register seq_check = (sw == seq_reg), using sw sampled in that same cycle, and move to RESULT.
REQ-015 In ANSWER, if the counter is 0 and enter_edge=0, the block SHALL register seq_check=0, set a timeout flag, and move to RESULT.
REQ-016 If enter_edge=1 and the counter is 0 in the same cycle, the enter path SHALL win and no timeout SHALL be flagged.
REQ-017 In RESULT (exactly 1 cycle): result_valid=1, timeout equals the flag, and the next state SHALL be IDLE.
REQ-018 seq_check SHALL hold its value until the next RESULT cycle.
REQ-019 busy SHALL be 1 in LOAD, SHOW, ANSWER and RESULT.
REQ-020 Latency: with seq_ld sampled in cycle N, led SHALL first show the pattern in cycle N+2.

Reset
REQ-021 reset=1 SHALL, on the next edge and from any state (including mid-round), set: state=IDLE, lfsr=8'hA5, seq_reg=0, counter=0, enter_prev=0, seq_check=0, and the timeout flag=0.
REQ-022 While reset=1, every output SHALL be 0, and any round in progress SHALL be discarded with no result_valid pulse.

Structure
REQ-023 A shared package round_pkg SHALL hold the state enum (3-bit), SEQ_W=8, LFSR_SEED=8'hA5 and the LFSR tap mask 8'hB8.
REQ-024 The LFSR SHALL be a separate sub-module, lfsr8, with ports clk, reset, step and value[7:0].
REQ-025 The counter SHALL be 32 bits wide and shared between the SHOW and ANSWER phases.

Verification (SHOW_CYCLES=4, TIMEOUT_CYCLES=8)
REQ-026 Reset, then pulse seq_ld -> led=8'h4A for exactly 4 cycles, starting 2 cycles after seq_ld; then led=0.
REQ-027 Round 1: sw=8'h4A and an enter rising edge in ANSWER -> one cycle with result_valid=1, seq_check=1, timeout=0.
REQ-028 Round 2: led=8'h95; sw=8'h00 and an enter edge -> result_valid=1, seq_check=0, timeout=0.
REQ-029 No enter during ANSWER -> exactly 8 ANSWER cycles, then result_valid=1, timeout=1, seq_check=0.
REQ-030 Enter held high from the SHOW phase through ANSWER -> no edge is seen, so the round times out; an enter edge landing in the last ANSWER cycle (counter=0) -> timeout=0.
REQ-031 Assert reset during SHOW -> next cycle state_out=0, led=0, busy=0; the next seq_ld shows 8'h4A again.

Source files
------------

// File: rtl/round_pkg.sv
// Shared types and constants for the round sequencer.
// Holds the FSM state enum, pattern width, LFSR seed/taps and step function.
package round_pkg;

  localparam int SEQ_W = 8;

  localparam logic [SEQ_W-1:0] LFSR_SEED = 8'hA5;
  localparam logic [SEQ_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SHOW   = 3'd2,
    S_ANSWER = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  // Fibonacci step: taps at bits 7,5,4,3 feed bit 0.
  function automatic logic [SEQ_W-1:0] lfsr_next(
    input logic [SEQ_W-1:0] v
  );
    return {v[SEQ_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR pattern source, advanced one step per step pulse.
// Ports: clk, reset (sync, high), step, value[7:0] (current state).
module lfsr8
  import round_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  output logic [SEQ_W-1:0] value
);

  // Maximal-length taps from a nonzero seed never reach 0;
  // the zero guard only recovers from a corrupted register.
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= LFSR_SEED;
    end else if (value == '0) begin
      value <= LFSR_SEED;
    end else if (step) begin
      value <= lfsr_next(value);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Memory-game round: show an LFSR pattern, collect an answer, report result.
// Ports: clk, reset, seq_ld, enter, sw[7:0] in; led, seq_check,
// result_valid, timeout, busy, state_out[2:0] out.
module round_sequencer
  import round_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES    = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_ld,
  input  logic             enter,
  input  logic [SEQ_W-1:0] sw,
  output logic [SEQ_W-1:0] led,
  output logic             seq_check,
  output logic             result_valid,
  output logic             timeout,
  output logic             busy,
  output logic [2:0]       state_out
);

  localparam logic [31:0] SHOW_LOAD = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [SEQ_W-1:0] seq_reg;
  logic [31:0]      cnt;
  logic             enter_prev;
  logic             enter_edge;
  logic             to_flag;
  logic             chk_q;
  logic [SEQ_W-1:0] led_q;
  logic             busy_q;
  logic             rv_q;
  logic             to_q;
  logic [SEQ_W-1:0] lfsr_val;
  logic             lfsr_step;

  assign enter_edge = enter & ~enter_prev;
  assign lfsr_step  = (state == S_LOAD);

  lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .step  (lfsr_step),
    .value (lfsr_val)
  );

  // Outputs are registered for the state being entered;
  // reset additionally forces them low in the cycle it is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      seq_reg    <= '0;
      cnt        <= '0;
      enter_prev <= 1'b0;
      to_flag    <= 1'b0;
      chk_q      <= 1'b0;
      led_q      <= '0;
      busy_q     <= 1'b0;
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      enter_prev <= enter;
      rv_q       <= 1'b0;
      to_q       <= 1'b0;
      unique case (state)
        S_IDLE: begin
          led_q <= '0;
          if (seq_ld) begin
            state  <= S_LOAD;
            busy_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_LOAD: begin
          seq_reg <= lfsr_next(lfsr_val);
          led_q   <= lfsr_next(lfsr_val);
          cnt     <= SHOW_LOAD;
          to_flag <= 1'b0;
          busy_q  <= 1'b1;
          state   <= S_SHOW;
        end
        S_SHOW: begin
          busy_q <= 1'b1;
          if (cnt == '0) begin
            cnt   <= TO_LOAD;
            led_q <= '0;
            state <= S_ANSWER;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_ANSWER: begin
          busy_q <= 1'b1;
          led_q  <= '0;
          // A press on the final cycle beats the timer.
          if (enter_edge) begin
            chk_q   <= (sw == seq_reg);
            to_flag <= 1'b0;
            rv_q    <= 1'b1;
            to_q    <= 1'b0;
            state   <= S_RESULT;
          end else if (cnt == '0) begin
            chk_q   <= 1'b0;
            to_flag <= 1'b1;
            rv_q    <= 1'b1;
            to_q    <= 1'b1;
            state   <= S_RESULT;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_RESULT: begin
          busy_q <= 1'b0;
          led_q  <= '0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          led_q  <= '0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign led          = reset ? '0   : led_q;
  assign busy         = reset ? 1'b0 : busy_q;
  assign result_valid = reset ? 1'b0 : rv_q;
  assign timeout      = reset ? 1'b0 : (to_q & to_flag);
  assign seq_check    = reset ? 1'b0 : chk_q;
  assign state_out    = reset ? 3'd0 : state;

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer with short show/answer windows.
// Expected results are queued per round and matched on result_valid.
module tb_round_sequencer;

  localparam int SHOW = 4;
  localparam int TO   = 8;

  logic       clk;
  logic       reset;
  logic       seq_ld;
  logic       enter;
  logic [7:0] sw;
  logic [7:0] led;
  logic       seq_check;
  logic       result_valid;
  logic       timeout;
  logic       busy;
  logic [2:0] state_out;

  int checks;
  int errors;
  logic [1:0] exp_q[$];
  logic [7:0] model_lfsr;

  round_sequencer #(
    .SHOW_CYCLES    (SHOW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seq_ld       (seq_ld),
    .enter        (enter),
    .sw           (sw),
    .led          (led),
    .seq_check    (seq_check),
    .result_valid (result_valid),
    .timeout      (timeout),
    .busy         (busy),
    .state_out    (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_step(input logic [7:0] v);
    logic fb;
    fb = v[7] ^ v[5] ^ v[4] ^ v[3];
    return {v[6:0], fb};
  endfunction

  // Scoreboard: each result pulse consumes one queued {seq_check, timeout}.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result chk=%b to=%b", seq_check, timeout);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        if ({seq_check, timeout} !== e) begin
          errors++;
          $display("FAIL result got chk/to=%b%b want %b",
                   seq_check, timeout, e);
        end
      end
    end else if (timeout !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL stray_timeout got %b want 0", timeout);
    end
  end

  task automatic play_round(
    input logic [7:0] pat,
    input logic [7:0] sw_val,
    input int         press_at,
    input int         hold_from,
    input int         ld_at,
    input int         exp_rv_at,
    input logic       exp_chk
  );
    int first;
    int shown;
    int rv_at;
    first = -1;
    shown = 0;
    rv_at = -1;
    sw = sw_val;
    @(posedge clk); #1 seq_ld = 1'b1;
    @(posedge clk); #1 seq_ld = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      enter  = (press_at >= 0 && i == 6 + press_at) ||
               (hold_from > 0 && i >= hold_from);
      seq_ld = (i == ld_at);
      @(negedge clk);
      if (led !== 8'h00) begin
        if (first < 0) first = i;
        shown++;
        checks++;
        if (led !== pat) begin
          errors++;
          $display("FAIL led_pattern got %h want %h", led, pat);
        end
      end
      if (result_valid === 1'b1) begin
        rv_at = i;
        break;
      end
      @(posedge clk); #1;
    end
    enter  = 1'b0;
    seq_ld = 1'b0;
    checks++;
    if (first !== 2) begin
      errors++;
      $display("FAIL led_latency got %0d want 2", first);
    end
    checks++;
    if (shown !== SHOW) begin
      errors++;
      $display("FAIL led_cycles got %0d want %0d", shown, SHOW);
    end
    checks++;
    if (rv_at !== exp_rv_at) begin
      errors++;
      $display("FAIL result_cycle got %0d want %0d", rv_at, exp_rv_at);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({result_valid, busy, state_out, led} !== 13'd0) begin
      errors++;
      $display("FAIL after_result got rv=%b busy=%b st=%0d led=%h want 0",
               result_valid, busy, state_out, led);
    end
    checks++;
    if (seq_check !== exp_chk) begin
      errors++;
      $display("FAIL check_hold got %b want %b", seq_check, exp_chk);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    seq_ld = 1'b0;
    enter  = 1'b0;
    sw     = 8'h00;
    model_lfsr = 8'hA5;
    @(negedge clk);
    checks++;
    if ({led, seq_check, result_valid, timeout, busy, state_out} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got led=%h st=%0d busy=%b want 0",
               led, state_out, busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (state_out !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got st=%0d busy=%b want 0 0",
               state_out, busy);
    end
  endtask

  task automatic test_match;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b10);
    play_round(8'h4A, 8'h4A, 2, 0, 4, 9, 1'b1);
  endtask

  task automatic test_mismatch;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b00);
    play_round(8'h95, 8'h00, 0, 0, 8, 7, 1'b0);
  endtask

  task automatic test_timeout;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b01);
    play_round(model_lfsr, model_lfsr, -1, 0, 0, 6 + TO, 1'b0);
  endtask

  task automatic test_enter_held;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b01);
    play_round(model_lfsr, model_lfsr, -1, 3, 0, 6 + TO, 1'b0);
  endtask

  task automatic test_last_cycle_edge;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b10);
    play_round(model_lfsr, model_lfsr, TO - 1, 0, 0, 6 + TO, 1'b1);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1 seq_ld = 1'b1;
    @(posedge clk); #1 seq_ld = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({led, result_valid, timeout, busy, state_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs got led=%h st=%0d want 0",
               led, state_out);
    end
    @(posedge clk); #1 reset = 1'b0;
    model_lfsr = 8'hA5;
    @(negedge clk);
    checks++;
    if (state_out !== 3'd0 || led !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_mid got st=%0d led=%h busy=%b want 0",
               state_out, led, busy);
    end
    repeat (16) @(negedge clk);
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b00);
    play_round(8'h4A, 8'h11, 1, 0, 0, 8, 1'b0);
  endtask

  task automatic test_back_to_back;
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b10);
    play_round(8'h95, 8'h95, 3, 0, 0, 10, 1'b1);
    model_lfsr = model_step(model_lfsr);
    exp_q.push_back(2'b00);
    play_round(model_lfsr, ~model_lfsr, 5, 0, 0, 12, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_match();
    test_mismatch();
    test_timeout();
    test_enter_held();
    test_last_cycle_edge();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
